// File: rtl/mnist_canvas_ctrl.sv
// Drawing-canvas controller: PS/2 arrow-key cursor, paint/erase/sweep-clear of a multi-bit cell grid,
// and a free-running raster that streams the canvas into a vga_adapter plot port.
module mnist_canvas_ctrl #(
    parameter int GRID_W         = 28,
    parameter int GRID_H         = 28,
    parameter int PIXEL_SIZE     = 4,
    parameter int INTENSITY_BITS = 1,
    parameter int SOFT_BRUSH     = 0,
    parameter int MOVE_DELAY     = 2000000
) (
    input  logic                                     clk,
    input  logic                                     resetn,
    input  logic [7:0]                               scan_code,
    input  logic                                     scan_valid,
    input  logic                                     draw_en,
    input  logic                                     erase_en,
    input  logic                                     clear,
    output logic                                     busy,
    output logic [4:0]                               cursor_x,
    output logic [4:0]                               cursor_y,
    output logic [GRID_W*GRID_H*INTENSITY_BITS-1:0]  canvas_flat,
    output logic [7:0]                               vga_x,
    output logic [6:0]                               vga_y,
    output logic [2:0]                               vga_colour,
    output logic                                     plot,
    output logic                                     frame_done,
    output logic [1:0]                               key_state
);
    localparam int IB    = INTENSITY_BITS;
    localparam int NCELL = GRID_W * GRID_H;
    localparam int CD_W  = (MOVE_DELAY < 2) ? 1 : $clog2(MOVE_DELAY + 1);
    localparam int SUB_W = (PIXEL_SIZE < 2) ? 1 : $clog2(PIXEL_SIZE);
    localparam logic [IB-1:0] CELL_FULL = {IB{1'b1}};

    // Encoding is visible on key_state: 0 idle, 1 after E0, 2 after F0, 3 after E0 F0.
    typedef enum logic [1:0] {K_IDLE = 2'd0, K_EXT = 2'd1, K_BRK = 2'd2, K_EXT_BRK = 2'd3} key_t;

    key_t                 key_q;
    logic [CD_W-1:0]      cooldown;
    logic                 act, move_l, move_r, move_u, move_d, moved;
    logic                 draw_go, erase_go, stamp, stamped;
    logic [4:0]           clr_row;
    logic [NCELL*IB-1:0]  canvas_next;
    int                   cur_c, cur_r;
    logic [SUB_W-1:0]     sx_r, sy_r;
    logic [4:0]           col_r, row_r;
    logic [10:0]          ras_idx;
    logic [IB-1:0]        ras_cell;
    logic [2:0]           ras_colour;
    logic                 last_px;

    assign key_state = key_q;

    // Break codes and their following byte never act; a bare arrow code acts like its E0 form.
    assign act = scan_valid &&
                 (((key_q == K_EXT) && (scan_code != 8'hF0)) ||
                  ((key_q == K_IDLE) && (scan_code != 8'hE0) && (scan_code != 8'hF0)));
    assign move_l = act && (scan_code == 8'h6B) && (cursor_x != 5'd0);
    assign move_r = act && (scan_code == 8'h74) && (cursor_x != 5'(GRID_W - 1));
    assign move_u = act && (scan_code == 8'h75) && (cursor_y != 5'd0);
    assign move_d = act && (scan_code == 8'h72) && (cursor_y != 5'(GRID_H - 1));
    assign moved  = (cooldown == '0) && !busy && (move_l || move_r || move_u || move_d);

    assign erase_go = erase_en && !busy;
    assign draw_go  = draw_en && !erase_en && !busy;
    assign stamp    = draw_go && !stamped;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            key_q    <= K_IDLE;
            cursor_x <= 5'(GRID_W / 2);
            cursor_y <= 5'(GRID_H / 2);
            cooldown <= '0;
        end else begin
            if (scan_valid) begin
                case (key_q)
                    K_IDLE: begin
                        if (scan_code == 8'hE0)      key_q <= K_EXT;
                        else if (scan_code == 8'hF0) key_q <= K_BRK;
                    end
                    K_EXT:   key_q <= (scan_code == 8'hF0) ? K_EXT_BRK : K_IDLE;
                    default: key_q <= K_IDLE;
                endcase
            end
            if (moved) begin
                if (move_l) cursor_x <= cursor_x - 5'd1;
                if (move_r) cursor_x <= cursor_x + 5'd1;
                if (move_u) cursor_y <= cursor_y - 5'd1;
                if (move_d) cursor_y <= cursor_y + 5'd1;
                cooldown <= CD_W'(MOVE_DELAY);
            end else if (cooldown != '0) begin
                cooldown <= cooldown - CD_W'(1);
            end
        end
    end

    // A sweep row wins over painting; neighbours only see a stamp, never an erase.
    always_comb begin
        canvas_next = canvas_flat;
        cur_c = int'(cursor_x);
        cur_r = int'(cursor_y);
        for (int r = 0; r < GRID_H; r++) begin
            for (int c = 0; c < GRID_W; c++) begin
                if (busy) begin
                    if (r == int'(clr_row)) canvas_next[(r*GRID_W+c)*IB +: IB] = '0;
                end else if ((r == cur_r) && (c == cur_c)) begin
                    if (erase_go)     canvas_next[(r*GRID_W+c)*IB +: IB] = '0;
                    else if (draw_go) canvas_next[(r*GRID_W+c)*IB +: IB] = CELL_FULL;
                end else if ((SOFT_BRUSH != 0) && stamp &&
                             (((r == cur_r) && ((c == cur_c - 1) || (c == cur_c + 1))) ||
                              ((c == cur_c) && ((r == cur_r - 1) || (r == cur_r + 1)))) &&
                             (canvas_flat[(r*GRID_W+c)*IB +: IB] != CELL_FULL)) begin
                    canvas_next[(r*GRID_W+c)*IB +: IB] = canvas_flat[(r*GRID_W+c)*IB +: IB] + IB'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            canvas_flat <= '0;
            busy        <= 1'b0;
            clr_row     <= 5'd0;
            stamped     <= 1'b0;
        end else begin
            canvas_flat <= canvas_next;
            stamped     <= draw_go && !moved;
            if (busy) begin
                if (clr_row == 5'(GRID_H - 1)) busy <= 1'b0;
                clr_row <= clr_row + 5'd1;
            end else if (clear) begin
                busy    <= 1'b1;
                clr_row <= 5'd0;
            end
        end
    end

    always_comb begin
        ras_idx  = 11'(row_r) * 11'(GRID_W) + 11'(col_r);
        ras_cell = '0;
        for (int i = 0; i < NCELL; i++) begin
            if (int'(ras_idx) == i) ras_cell = canvas_flat[i*IB +: IB];
        end
        if ((row_r == cursor_y) && (col_r == cursor_x)) ras_colour = 3'b100;
        else if (ras_cell == CELL_FULL)                  ras_colour = 3'b111;
        else if (ras_cell != '0)                         ras_colour = 3'b011;
        else                                             ras_colour = 3'b001;
        last_px = (sx_r == SUB_W'(PIXEL_SIZE - 1)) && (sy_r == SUB_W'(PIXEL_SIZE - 1)) &&
                  (col_r == 5'(GRID_W - 1)) && (row_r == 5'(GRID_H - 1));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sx_r       <= '0;
            sy_r       <= '0;
            col_r      <= 5'd0;
            row_r      <= 5'd0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'b001;
            plot       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            vga_x      <= 8'(int'(col_r) * PIXEL_SIZE + int'(sx_r));
            vga_y      <= 7'(int'(row_r) * PIXEL_SIZE + int'(sy_r));
            vga_colour <= ras_colour;
            plot       <= 1'b1;
            frame_done <= last_px;
            if (sx_r == SUB_W'(PIXEL_SIZE - 1)) begin
                sx_r <= '0;
                if (sy_r == SUB_W'(PIXEL_SIZE - 1)) begin
                    sy_r <= '0;
                    if (col_r == 5'(GRID_W - 1)) begin
                        col_r <= 5'd0;
                        row_r <= (row_r == 5'(GRID_H - 1)) ? 5'd0 : row_r + 5'd1;
                    end else begin
                        col_r <= col_r + 5'd1;
                    end
                end else begin
                    sy_r <= sy_r + SUB_W'(1);
                end
            end else begin
                sx_r <= sx_r + SUB_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mnist_canvas_ctrl.sv
// Bench for mnist_canvas_ctrl: a cell-array/pixel-counter model of the canvas and raster, compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mnist_canvas_ctrl;
    localparam int GW    = 28;
    localparam int GH    = 28;
    localparam int PS    = 4;
    localparam int IB    = 2;
    localparam int SB    = 1;
    localparam int MD    = 40;
    localparam int NC    = GW * GH;
    localparam int FRAME = NC * PS * PS;
    localparam int FULL  = (1 << IB) - 1;

    logic             clk, resetn;
    logic [7:0]       scan_code;
    logic             scan_valid, draw_en, erase_en, clear;
    logic             busy;
    logic [4:0]       cursor_x, cursor_y;
    logic [NC*IB-1:0] canvas_flat;
    logic [7:0]       vga_x;
    logic [6:0]       vga_y;
    logic [2:0]       vga_colour;
    logic             plot, frame_done;
    logic [1:0]       key_state;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: key prefix 0 none, 1 E0, 2 F0, 3 E0 F0.
    int m_cell [NC];
    int m_cx, m_cy, m_key, cyc, cool_until, rows_left, pix;
    int e_x, e_y, e_col, e_plot, e_fd;
    bit m_stamped;
    bit model_on = 1'b0;

    mnist_canvas_ctrl #(
        .GRID_W(GW), .GRID_H(GH), .PIXEL_SIZE(PS), .INTENSITY_BITS(IB),
        .SOFT_BRUSH(SB), .MOVE_DELAY(MD)
    ) dut (
        .clk(clk), .resetn(resetn), .scan_code(scan_code), .scan_valid(scan_valid),
        .draw_en(draw_en), .erase_en(erase_en), .clear(clear), .busy(busy),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .canvas_flat(canvas_flat),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot),
        .frame_done(frame_done), .key_state(key_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic bump(input int r, input int c);
        if (r >= 0 && r < GH && c >= 0 && c < GW && m_cell[r*GW+c] < FULL)
            m_cell[r*GW+c] = m_cell[r*GW+c] + 1;
    endtask

    always @(posedge clk) begin : model
        int  p, ci, w, col, row, v, ocx, ocy, nx, ny;
        bit  ob, act, moved, dg;
        if (!resetn) begin
            for (int i = 0; i < NC; i++) m_cell[i] = 0;
            m_cx = GW / 2; m_cy = GH / 2; m_key = 0;
            cyc = 0; cool_until = 0; rows_left = 0; pix = 0; m_stamped = 1'b0;
            e_x = 0; e_y = 0; e_col = 1; e_plot = 0; e_fd = 0;
            model_on = 1'b1;
        end else if (model_on) begin
            ob = rows_left > 0; ocx = m_cx; ocy = m_cy;
            // Pixel number within the frame gives cell and sub-pixel position directly.
            p = pix % FRAME; ci = p / (PS*PS); w = p % (PS*PS);
            col = ci % GW; row = ci / GW;
            e_x = col*PS + w%PS; e_y = row*PS + w/PS;
            v = m_cell[row*GW+col];
            if (row == ocy && col == ocx) e_col = 4;
            else if (v == FULL)           e_col = 7;
            else if (v != 0)              e_col = 3;
            else                          e_col = 1;
            e_fd = (p == FRAME-1); e_plot = 1; pix++;
            moved = 1'b0;
            if (scan_valid) begin
                act = 1'b0;
                case (m_key)
                    0: if (scan_code == 8'hE0) m_key = 1; else if (scan_code == 8'hF0) m_key = 2; else act = 1'b1;
                    1: if (scan_code == 8'hF0) m_key = 3; else begin act = 1'b1; m_key = 0; end
                    default: m_key = 0;
                endcase
                if (act && cyc >= cool_until && !ob) begin
                    nx = ocx; ny = ocy;
                    case (scan_code)
                        8'h6B: nx = ocx - 1;
                        8'h74: nx = ocx + 1;
                        8'h75: ny = ocy - 1;
                        8'h72: ny = ocy + 1;
                        default: ;
                    endcase
                    if (nx >= 0 && nx < GW && ny >= 0 && ny < GH && (nx != ocx || ny != ocy)) begin
                        m_cx = nx; m_cy = ny; moved = 1'b1; cool_until = cyc + MD + 1;
                    end
                end
            end
            dg = draw_en && !erase_en && !ob;
            if (!ob) begin
                if (erase_en) m_cell[ocy*GW+ocx] = 0;
                else if (draw_en) begin
                    if (SB != 0 && !m_stamped) begin
                        bump(ocy, ocx-1); bump(ocy, ocx+1); bump(ocy-1, ocx); bump(ocy+1, ocx);
                    end
                    m_cell[ocy*GW+ocx] = FULL;
                end
            end
            m_stamped = dg && !moved;
            if (ob) begin
                for (int c = 0; c < GW; c++) m_cell[(GH-rows_left)*GW+c] = 0;
                rows_left--;
            end else if (clear) begin
                rows_left = GH;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin : compare
        logic [NC*IB-1:0] exp_flat;
        int bad;
        if (model_on) begin
            chk("cursor_x", 32'(cursor_x), m_cx);
            chk("cursor_y", 32'(cursor_y), m_cy);
            chk("busy", 32'(busy), 32'(rows_left > 0));
            chk("key_state", 32'(key_state), m_key);
            chk("plot", 32'(plot), e_plot);
            chk("vga_x", 32'(vga_x), e_x);
            chk("vga_y", 32'(vga_y), e_y);
            chk("vga_colour", 32'(vga_colour), e_col);
            chk("frame_done", 32'(frame_done), e_fd);
            bad = -1;
            for (int i = 0; i < NC; i++) begin
                exp_flat[i*IB +: IB] = IB'(m_cell[i]);
                if (bad < 0 && canvas_flat[i*IB +: IB] !== exp_flat[i*IB +: IB]) bad = i;
            end
            if (bad < 0) bad = 0;
            n_cmp++;
            if (canvas_flat !== exp_flat) begin
                n_fail++;
                $display("FAIL canvas: cell %0d got %0d expected %0d at t=%0t",
                         bad, canvas_flat[bad*IB +: IB], m_cell[bad], $time);
            end
        end
    end

    task automatic send_key(input logic [7:0] code);
        @(negedge clk); scan_code = code; scan_valid = 1'b1;
        @(negedge clk); scan_valid = 1'b0;
    endtask

    task automatic wait_cool();
        repeat (MD + 2) @(negedge clk);
    endtask

    task automatic wait_pixel(input int x, input int y, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < FRAME + 8 && !ok; i++) begin
            @(negedge clk);
            if (plot === 1'b1 && vga_x == 8'(x) && vga_y == 7'(y)) ok = 1'b1;
        end
    endtask

    task automatic wait_frame_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < FRAME + 8 && !ok; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) ok = 1'b1;
        end
    endtask

    initial begin
        #950000;
        n_fail++;
        $display("FAIL watchdog: time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n, saved_x;
        logic [7:0] code;
        resetn = 1'b0; scan_code = 8'h00; scan_valid = 1'b0;
        draw_en = 1'b0; erase_en = 1'b0; clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_plot", 32'(plot), 0);
        chk("rst_colour", 32'(vga_colour), 1);
        chk("rst_cursor_x", 32'(cursor_x), 14);
        chk("rst_canvas", 32'(|canvas_flat), 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("first_px_x", 32'(vga_x), 0);
        chk("first_px_plot", 32'(plot), 1);

        send_key(8'hE0); send_key(8'h74);
        chk("move_right", 32'(cursor_x), 15);
        send_key(8'hE0); send_key(8'h74);
        chk("cooldown_drop", 32'(cursor_x), 15);
        repeat (MD) @(negedge clk);
        send_key(8'hE0); send_key(8'h74);
        chk("move_after_cooldown", 32'(cursor_x), 16);

        wait_cool();
        send_key(8'hE0); send_key(8'hF0); send_key(8'h74);
        chk("ext_break_no_move", 32'(cursor_x), 16);
        chk("ext_break_idle", 32'(key_state), 0);
        send_key(8'hF0); send_key(8'h1C);
        chk("break_idle", 32'(key_state), 0);

        repeat (16) begin send_key(8'hE0); send_key(8'h6B); wait_cool(); end
        chk("left_edge", 32'(cursor_x), 0);
        send_key(8'hE0); send_key(8'h6B);
        chk("clamp_left", 32'(cursor_x), 0);
        send_key(8'hE0); send_key(8'h74);
        chk("clamp_no_cooldown", 32'(cursor_x), 1);
        repeat (13) begin wait_cool(); send_key(8'h74); end
        chk("bare_arrows", 32'(cursor_x), 14);

        wait_cool();
        @(negedge clk); draw_en = 1'b1;
        @(negedge clk); draw_en = 1'b0;
        chk("cell406_full", 32'(canvas_flat[406*IB +: IB]), 3);
        chk("nbr405", 32'(canvas_flat[405*IB +: IB]), 1);
        chk("nbr407", 32'(canvas_flat[407*IB +: IB]), 1);
        chk("nbr378", 32'(canvas_flat[378*IB +: IB]), 1);
        chk("nbr434", 32'(canvas_flat[434*IB +: IB]), 1);
        wait_pixel(56, 56, ok);
        chk("px_56_found", 32'(ok), 1);
        chk("cursor_colour", 32'(vga_colour), 4);
        send_key(8'hE0); send_key(8'h74);
        wait_pixel(56, 56, ok);
        chk("px_56_found2", 32'(ok), 1);
        chk("painted_colour", 32'(vga_colour), 7);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 7))
                0: code = 8'hE0;
                1: code = 8'hF0;
                2: code = 8'h6B;
                3: code = 8'h74;
                4: code = 8'h75;
                5: code = 8'h72;
                6: code = 8'h1C;
                default: code = 8'($urandom);
            endcase
            scan_code  = code;
            scan_valid = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 11) == 0) draw_en = ~draw_en;
            if ($urandom_range(0, 24) == 0) erase_en = ~erase_en;
            clear = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        scan_valid = 1'b0; draw_en = 1'b0; erase_en = 1'b0; clear = 1'b0;
        repeat (GH + 2) @(negedge clk);

        wait_cool();
        draw_en = 1'b1;
        repeat (5) begin send_key(8'h72); wait_cool(); end
        draw_en = 1'b0;
        saved_x = int'(cursor_x);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == 2) begin clear = 1'b1; scan_code = 8'h74; scan_valid = 1'b1; end
            else begin clear = 1'b0; scan_valid = 1'b0; end
            @(negedge clk);
        end
        clear = 1'b0; scan_valid = 1'b0;
        chk("busy_len", n, 28);
        chk("clear_zero", 32'(|canvas_flat), 0);
        chk("busy_move_dropped", 32'(cursor_x), saved_x);

        wait_frame_done(ok);
        chk("frame_done_found", 32'(ok), 1);
        chk("last_px_x", 32'(vga_x), 111);
        chk("last_px_y", 32'(vga_y), 111);
        n = 0; ok = 1'b0;
        while (!ok && n < FRAME + 8) begin
            @(negedge clk);
            n++;
            if (frame_done === 1'b1) ok = 1'b1;
        end
        chk("frame_period", n, 12544);

        repeat (300) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midframe_rst_plot", 32'(plot), 0);
        chk("midframe_rst_cursor", 32'(cursor_x), 14);
        resetn = 1'b1;
        @(negedge clk);
        chk("restart_x", 32'(vga_x), 0);
        chk("restart_y", 32'(vga_y), 0);
        chk("restart_plot", 32'(plot), 1);
        repeat (50) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
